// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction memory, buffers words in a small FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises fetch_fault and halts fetch until an aligned redirect.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir_out,
  output logic [31:0] ir_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_reg;
  logic [31:0]   req_pc_reg;
  logic [31:0]   ir_out_reg;
  logic [31:0]   ir_pc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic          inflight_reg;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];

  logic          credit_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic          fault_reg;
  logic [31:0]   redirect_target;
  logic [CW:0]   occupancy;
  logic          head_load;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_target = redirect_pc;
  assign fetch_fault     = fault_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fault_reg <= 1'b0;
    end else if (redirect) begin
      fault_reg <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign fault_reg       = 1'b0;
`endif

  // Words already buffered plus the one in flight must fit, so a push never meets a full buffer.
  assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign credit_ok = occupancy < (CW+1)'(DEPTH);
  assign issue     = run & ~redirect & ~fault_reg & credit_ok;
  assign push      = inflight_reg & ~redirect;
  assign ir_valid  = (count_reg != '0);
  assign pop       = ir_valid & ir_ready & ~redirect;

  assign mem_rd     = issue;
  assign mem_addr   = pc_reg;
  assign ir_out     = ir_out_reg;
  assign ir_pc      = ir_pc_reg;
  assign count_next = count_reg + CW'(push) - CW'(pop);

  // The head is registered so it keeps its last value once the buffer drains.
  always_comb begin
    head_load  = 1'b0;
    head_instr = mem_rdata;
    head_pc    = req_pc_reg;
    if (push && ((count_reg == '0) || (pop && (count_reg == CW'(1))))) begin
      head_load = 1'b1;
    end else if (pop && (count_reg > CW'(1))) begin
      head_load  = 1'b1;
      head_instr = buf_instr[rd_ptr_reg + PW'(1)];
      head_pc    = buf_pc[rd_ptr_reg + PW'(1)];
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_instr[wr_ptr_reg] <= mem_rdata;
      buf_pc[wr_ptr_reg]    <= req_pc_reg;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_reg       <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      ir_out_reg   <= '0;
      ir_pc_reg    <= '0;
    end else if (redirect) begin
      pc_reg       <= redirect_target;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      if (issue) begin
        pc_reg     <= pc_reg + 32'd4;
        req_pc_reg <= pc_reg;
      end
      inflight_reg <= issue;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      if (head_load) begin
        ir_out_reg <= head_instr;
        ir_pc_reg  <= head_pc;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: a cycle table for streaming, back-pressure, redirect and run-stop, plus alignment.
module tb_riscv_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock;
  logic        resetn;
  logic        run;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_rd, mem_rd2;
  logic [31:0] mem_addr, mem_addr2;
  logic [31:0] mem_rdata, mem_rdata2;
  logic        ir_valid, ir_valid2;
  logic [31:0] ir_out, ir_out2;
  logic [31:0] ir_pc, ir_pc2;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault, fetch_fault2;
`endif

  int n_pass;
  int n_total;

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clock(clock), .resetn(resetn), .run(run),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_out(ir_out), .ir_pc(ir_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  riscv_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clock(clock), .resetn(resetn), .run(run),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .ir_valid(ir_valid2), .ir_ready(ir_ready), .ir_out(ir_out2), .ir_pc(ir_pc2),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memories: word = address ^ KEY, one cycle after the strobe.
  always @(posedge clock) begin
    if (mem_rd)  mem_rdata  <= mem_addr ^ KEY;
    if (mem_rd2) mem_rdata2 <= mem_addr2 ^ KEY;
  end

  typedef struct packed {
    logic        rst;
    logic        chk2;
    logic        run;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e2_rd;
    logic [31:0] e2_addr;
    logic        e2_valid;
    logic [31:0] e2_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic r, logic rdy, logic redir, logic [31:0] rpc,
                              logic erd, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v = '0;
    v.rst = rst; v.run = r; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_rd = erd; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  function automatic vec_t mk2(logic rst, logic erd, logic [31:0] ea, logic ev, logic [31:0] ep,
                               logic e2rd, logic [31:0] e2a, logic e2v, logic [31:0] e2p);
    vec_t v;
    v = mk(rst, 1'b1, 1'b1, 1'b0, 32'h0, erd, ea, ev, ep);
    v.chk2 = 1'b1; v.e2_rd = e2rd; v.e2_addr = e2a; v.e2_valid = e2v; v.e2_pc = e2p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; run = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    check("reset mem_rd",   32'(mem_rd),   32'h0);
    check("reset mem_addr", mem_addr,      32'h0);
    check("reset ir_valid", 32'(ir_valid), 32'h0);
    check("reset ir_out",   ir_out,        32'h0);
    check("reset ir_pc",    ir_pc,         32'h0);
    check("reset mem_addr2", mem_addr2,    32'hFFFF_FFF8);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    resetn = 1'b0; run = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Streaming from reset, both instances (DEPTH 2 at 0, DEPTH 4 wrapping from FFFF_FFF8).
    tbl.push_back(mk2(1, 1, 32'h00, 0, 32'h00, 1, 32'hFFFF_FFF8, 0, 32'h0));
    tbl.push_back(mk2(0, 1, 32'h04, 0, 32'h00, 1, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(mk2(0, 0, 32'h08, 1, 32'h00, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8));
    tbl.push_back(mk2(0, 1, 32'h08, 1, 32'h04, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC));
    tbl.push_back(mk2(0, 1, 32'h0C, 0, 32'h04, 1, 32'h0000_0008, 1, 32'h0000_0000));
    tbl.push_back(mk2(0, 0, 32'h10, 1, 32'h08, 1, 32'h0000_000C, 1, 32'h0000_0004));
    tbl.push_back(mk2(0, 1, 32'h10, 1, 32'h0C, 1, 32'h0000_0010, 1, 32'h0000_0008));
    // Back-pressure: buffer fills with 0 and 4, one pop releases exactly one request to 8.
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 32'h00, 0, 32'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h04, 0, 32'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h08, 1, 32'h04));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0C, 1, 32'h04));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0C, 1, 32'h04));
    // Redirect to 0x100 while the response for 8 returns: that word is dropped.
    tbl.push_back(mk(1, 1, 1, 0, 0,       1, 32'h000, 0, 32'h000));
    tbl.push_back(mk(0, 1, 1, 0, 0,       1, 32'h004, 0, 32'h000));
    tbl.push_back(mk(0, 1, 1, 0, 0,       0, 32'h008, 1, 32'h000));
    tbl.push_back(mk(0, 1, 1, 0, 0,       1, 32'h008, 1, 32'h004));
    tbl.push_back(mk(0, 1, 1, 1, 32'h100, 0, 32'h00C, 0, 32'h004));
    tbl.push_back(mk(0, 1, 1, 0, 0,       1, 32'h100, 0, 32'h004));
    tbl.push_back(mk(0, 1, 1, 0, 0,       1, 32'h104, 0, 32'h004));
    tbl.push_back(mk(0, 1, 1, 0, 0,       0, 32'h108, 1, 32'h100));
    tbl.push_back(mk(0, 1, 1, 0, 0,       1, 32'h108, 1, 32'h104));
    // run dropped after issuing 4: the word for 4 still arrives, no strobes until run returns.
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 32'h00, 0, 32'h00));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h04, 0, 32'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h08, 1, 32'h04));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h08, 0, 32'h04));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h08, 0, 32'h04));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h08, 0, 32'h04));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h0C, 0, 32'h04));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h10, 1, 32'h08));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      @(negedge clock);
      run = tbl[i].run; ir_ready = tbl[i].rdy; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      #1;
      check($sformatf("row%0d mem_rd", i),   32'(mem_rd),   32'(tbl[i].e_rd));
      check($sformatf("row%0d mem_addr", i), mem_addr,      tbl[i].e_addr);
      check($sformatf("row%0d ir_valid", i), 32'(ir_valid), 32'(tbl[i].e_valid));
      check($sformatf("row%0d ir_pc", i),    ir_pc,         tbl[i].e_pc);
      if (tbl[i].e_valid) check($sformatf("row%0d ir_out", i), ir_out, tbl[i].e_pc ^ KEY);
      if (tbl[i].chk2) begin
        check($sformatf("row%0d mem_rd2", i),   32'(mem_rd2),   32'(tbl[i].e2_rd));
        check($sformatf("row%0d mem_addr2", i), mem_addr2,      tbl[i].e2_addr);
        check($sformatf("row%0d ir_valid2", i), 32'(ir_valid2), 32'(tbl[i].e2_valid));
        check($sformatf("row%0d ir_pc2", i),    ir_pc2,         tbl[i].e2_pc);
        if (tbl[i].e2_valid) check($sformatf("row%0d ir_out2", i), ir_out2, tbl[i].e2_pc ^ KEY);
      end
    end

    // Misaligned redirect to 0x102.
    do_reset();
    @(negedge clock);
    run = 1'b1; ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
    #1 check("mis redirect mem_rd", 32'(mem_rd), 32'h0);
    @(negedge clock);
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    #1;
    check("mis fault set", 32'(fetch_fault), 32'h1);
    check("mis halted rd", 32'(mem_rd), 32'h0);
    @(negedge clock);
    #1;
    check("mis fault hold", 32'(fetch_fault), 32'h1);
    check("mis halted rd2", 32'(mem_rd), 32'h0);
    @(negedge clock);
    redirect = 1'b1; redirect_pc = 32'h200;
    #1 check("mis re-redirect rd", 32'(mem_rd), 32'h0);
    @(negedge clock);
    redirect = 1'b0;
    #1;
    check("mis fault clear", 32'(fetch_fault), 32'h0);
    check("mis resume rd", 32'(mem_rd), 32'h1);
    check("mis resume addr", mem_addr, 32'h200);
`else
    #1;
    check("mis aligned rd", 32'(mem_rd), 32'h1);
    check("mis aligned addr", mem_addr, 32'h100);
    @(negedge clock);
    #1 check("mis next addr", mem_addr, 32'h104);
    @(negedge clock);
    #1;
    check("mis ir_valid", 32'(ir_valid), 32'h1);
    check("mis ir_pc", ir_pc, 32'h100);
    check("mis ir_out", ir_out, 32'h100 ^ KEY);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
